mem_arbiter: RTL and testbench

Two-port arbiter and burst sequencer for the unified `memory` block of the MIPS processor. It shares the single memory port between the instruction-fetch requester (port 0) and the load/store requester (port 1). It also drives multi-word bursts per `access_size` and routes read data back to the owning port. It sits between the pipeline's fetch/memory stages and `memory`.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_rr_arb2.sv | 30 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_pkg: shared definitions for the memory arbiter.
//   - access_size encodings and beats() helper (1/4/8/16 words)
//   - FSM state enum
//   - START_ADDR: base of the memory image
package mem_pkg;

  localparam logic [1:0] SIZE_1  = 2'b00;
  localparam logic [1:0] SIZE_4  = 2'b01;
  localparam logic [1:0] SIZE_8  = 2'b10;
  localparam logic [1:0] SIZE_16 = 2'b11;

  localparam logic [31:0] START_ADDR = 32'h8002_0000;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  function automatic logic [4:0] beats(input logic [1:0] size);
    case (size)
      SIZE_1:  return 5'd1;
      SIZE_4:  return 5'd4;
      SIZE_8:  return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes (ports 0/1) plus the memory-side bus.
//   slave  : arbiter view (takes requests, drives grants/data and mem_*)
//   master : requester + memory model view (the reverse)
interface mem_arbiter_if #(
  parameter int data_width    = 32,
  parameter int address_width = 32
);
  logic                     req_0, req_1;
  logic                     rw_0, rw_1;
  logic [address_width-1:0] addr_0, addr_1;
  logic [1:0]               size_0, size_1;
  logic [data_width-1:0]    wdata_0, wdata_1;
  logic                     gnt_0, gnt_1;
  logic                     wready_0, wready_1;
  logic                     rvalid_0, rvalid_1;
  logic                     done_0, done_1;
  logic [data_width-1:0]    rdata;
  logic [address_width-1:0] mem_address;
  logic [data_width-1:0]    mem_data_in;
  logic [1:0]               mem_access_size;
  logic                     mem_rw;
  logic                     mem_enable;
  logic                     mem_busy;
  logic [data_width-1:0]    mem_data_out;

  modport slave (
    input  req_0, req_1, rw_0, rw_1, addr_0, addr_1, size_0, size_1,
           wdata_0, wdata_1, mem_busy, mem_data_out,
    output gnt_0, gnt_1, wready_0, wready_1, rvalid_0, rvalid_1,
           done_0, done_1, rdata, mem_address, mem_data_in,
           mem_access_size, mem_rw, mem_enable
  );

  modport master (
    output req_0, req_1, rw_0, rw_1, addr_0, addr_1, size_0, size_1,
           wdata_0, wdata_1, mem_busy, mem_data_out,
    input  gnt_0, gnt_1, wready_0, wready_1, rvalid_0, rvalid_1,
           done_0, done_1, rdata, mem_address, mem_data_in,
           mem_access_size, mem_rw, mem_enable
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant.
//   req : request vector {port1, port0}
//   en  : arbitration slot (pointer moves only when a grant is taken here)
//   gnt : one-hot winner, combinational
// The pointer remembers the last winner; on a tie the other port wins.
// Reset leaves the pointer at port 0 so port 1 wins the first tie.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_q;  // 1: port 1 won most recently

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)           last_q <= 1'b0;
    else if (en && (|req))  last_q <= gnt[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between instruction fetch
// (port 0) and load/store (port 1), sequencing 1/4/8/16-word bursts.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : per-port req/rw/addr/size/wdata in; gnt/wready/rvalid/
//                    done/rdata out; mem_* towards memory, mem_busy and
//                    mem_data_out back from it.
// Read data comes back one cycle after each consumed read beat, hence the
// registered rvalid and the DRAIN state that covers the final returned beat.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int data_width    = 32,
  parameter int address_width = 32
) (
  input logic clock,
  input logic reset_n,
  mem_arbiter_if.slave bus
);
  state_t state, state_nxt;

  logic [1:0]               req, win;
  logic                     owner, rw_q, first_q, rvalid_q, rdone_q;
  logic [1:0]               size_q;
  logic [3:0]               beat;
  logic [address_width-1:0] base_q, addr_sel;
  logic                     rw_sel;
  logic [1:0]               size_sel;
  logic                     idle, xfer, start, take, last, wr_beat;
  logic [data_width-1:0]    wdata_own;

  assign req   = {bus.req_1, bus.req_0};
  assign idle  = (state == IDLE);
  assign xfer  = (state == XFER);
  assign start = idle && (|req);
  assign take  = xfer && !bus.mem_busy;
  assign last  = ({1'b0, beat} == (beats(size_q) - 5'd1));
  assign wr_beat = take && !rw_q;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .en      (idle),
    .gnt     (win)
  );

  assign rw_sel    = win[1] ? bus.rw_1   : bus.rw_0;
  assign size_sel  = win[1] ? bus.size_1 : bus.size_0;
  assign addr_sel  = win[1] ? bus.addr_1 : bus.addr_0;
  assign wdata_own = owner  ? bus.wdata_1 : bus.wdata_0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = XFER;
      XFER:    if (take && last) state_nxt = rw_q ? DRAIN : IDLE;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= 1'b0;
      rw_q     <= 1'b0;
      size_q   <= '0;
      base_q   <= '0;
      beat     <= '0;
      first_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdone_q  <= 1'b0;
    end else begin
      first_q  <= start;
      rvalid_q <= take && rw_q;
      rdone_q  <= take && rw_q && last;
      if (start) begin
        owner  <= win[1];
        rw_q   <= rw_sel;
        size_q <= size_sel;
        base_q <= addr_sel & ~address_width'(3);
        beat   <= '0;
      end else if (take) begin
        // counter returns to 0 only when the burst completes
        beat <= last ? 4'd0 : beat + 4'd1;
      end
    end
  end

  always_comb begin
    bus.mem_enable      = 1'b0;
    bus.mem_rw          = 1'b0;
    bus.mem_access_size = '0;
    bus.mem_address     = '0;
    bus.mem_data_in     = '0;
    if (xfer) begin
      bus.mem_enable      = 1'b1;
      bus.mem_rw          = rw_q;
      bus.mem_access_size = size_q;
      bus.mem_address     = base_q + address_width'({beat, 2'b00});
      bus.mem_data_in     = rw_q ? '0 : wdata_own;
    end
  end

  // first_q is only ever set on the IDLE->XFER edge, so it marks the
  // first XFER cycle regardless of mem_busy.
  assign bus.gnt_0    = first_q && !owner;
  assign bus.gnt_1    = first_q &&  owner;
  assign bus.wready_0 = wr_beat && !owner;
  assign bus.wready_1 = wr_beat &&  owner;
  assign bus.rvalid_0 = rvalid_q && !owner;
  assign bus.rvalid_1 = rvalid_q &&  owner;
  assign bus.done_0   = !owner && ((wr_beat && last) || rdone_q);
  assign bus.done_1   =  owner && ((wr_beat && last) || rdone_q);
  assign bus.rdata    = rvalid_q ? bus.mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clock;
  logic reset_n;
  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: registered read, data valid the cycle after the beat.
  logic [31:0] mem [256];
  bit          wr  [256];
  logic [7:0]  midx;
  assign midx = bus.mem_address[9:2];

  function automatic logic [31:0] mem_init(input int idx);
    if (idx >= 4 && idx <= 7) return 32'h11 * (idx - 3);
    if (idx == 1) return 32'hA5A5_0001;
    return 32'hC000_0000 | idx;
  endfunction

  always @(posedge clock) begin
    if (bus.mem_enable && !bus.mem_busy) begin
      if (bus.mem_rw) bus.mem_data_out <= wr[midx] ? mem[midx] : mem_init(int'(midx));
      else begin
        mem[midx] <= bus.mem_data_in;
        wr[midx]  <= 1'b1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_flags"}, {24'd0, bus.gnt_0, bus.gnt_1, bus.wready_0, bus.wready_1,
                            bus.rvalid_0, bus.rvalid_1, bus.done_0, bus.done_1}, 32'd0);
    chk({name, "_men"},   {31'd0, bus.mem_enable}, 32'd0);
    chk({name, "_mrw"},   {31'd0, bus.mem_rw}, 32'd0);
    chk({name, "_msize"}, {30'd0, bus.mem_access_size}, 32'd0);
    chk({name, "_maddr"}, bus.mem_address, 32'd0);
    chk({name, "_mdin"},  bus.mem_data_in, 32'd0);
    chk({name, "_rdata"}, bus.rdata, 32'd0);
  endtask

  task automatic drive_port(input bit p, input bit r, input bit rw, input logic [31:0] a,
                            input logic [1:0] s, input logic [31:0] wd);
    if (p) begin
      bus.req_1 = r; bus.rw_1 = rw; bus.addr_1 = a; bus.size_1 = s; bus.wdata_1 = wd;
    end else begin
      bus.req_0 = r; bus.rw_0 = rw; bus.addr_0 = a; bus.size_0 = s; bus.wdata_0 = wd;
    end
  endtask

  typedef struct {
    bit          port;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order[4];
    int got, t, nw, eb;
    bit p, bsy;

    vt[0] = '{1'b1, 1'b0, 32'h8002_0000, 32'hDEAD_BEEF, 32'h8002_0000, 32'h0};
    vt[1] = '{1'b0, 1'b0, 32'h8002_0020, 32'h1234_5678, 32'h8002_0020, 32'h0};
    vt[2] = '{1'b1, 1'b1, 32'h8002_0006, 32'h0,         32'h8002_0004, 32'hA5A5_0001};
    vt[3] = '{1'b0, 1'b1, 32'h8002_0000, 32'h0,         32'h8002_0000, 32'hDEAD_BEEF};
    vt[4] = '{1'b1, 1'b1, 32'h8002_0023, 32'h0,         32'h8002_0020, 32'h1234_5678};
    exp_order = '{1, 0, 1, 0};

    reset_n = 1'b0;
    bus.mem_busy = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h5555_AAAA);
    #12;
    chk_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Round robin after reset: both requesting 1-word reads
    step();
    drive_port(1'b0, 1'b1, 1'b1, START_ADDR,         SIZE_1, 32'h0);
    drive_port(1'b1, 1'b1, 1'b1, START_ADDR + 32'h4, SIZE_1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      do begin
        step(); #2; t++;
      end while (!(bus.gnt_0 || bus.gnt_1) && t < 10);
      if (!(bus.gnt_0 || bus.gnt_1)) begin
        chk("rr_grant_timeout", 32'd0, 32'd1);
        break;
      end
      got = bus.gnt_1 ? 1 : 0;
      chk("rr_order", got, exp_order[k]);
      if (got == 1) bus.req_1 = 1'b0; else bus.req_0 = 1'b0;
      step(); #2;
      chk("rr_done", got == 1 ? bus.done_1 : bus.done_0, 32'd1);
      chk("rr_rdata", bus.rdata, got == 1 ? 32'hA5A5_0001 : 32'hC000_0000);
      if (k == 3) begin
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
      end else if (got == 1) bus.req_1 = 1'b1;
      else bus.req_0 = 1'b1;
    end

    // Single-word vector table
    for (int i = 0; i < 5; i++) begin
      p = vt[i].port;
      step();
      drive_port(p, 1'b1, vt[i].rw, vt[i].addr, SIZE_1, vt[i].wdata);
      #2;
      chk("vec_idle_gnt", {bus.gnt_1, bus.gnt_0}, 32'd0);
      step();
      if (p) bus.req_1 = 1'b0; else bus.req_0 = 1'b0;
      #2;
      chk("vec_gnt",   p ? bus.gnt_1 : bus.gnt_0, 32'd1);
      chk("vec_men",   bus.mem_enable, 32'd1);
      chk("vec_mrw",   bus.mem_rw, vt[i].rw);
      chk("vec_maddr", bus.mem_address, vt[i].exp_addr);
      if (!vt[i].rw) begin
        chk("vec_wready", p ? bus.wready_1 : bus.wready_0, 32'd1);
        chk("vec_wdone",  p ? bus.done_1 : bus.done_0, 32'd1);
        chk("vec_mdin",   bus.mem_data_in, vt[i].wdata);
      end else begin
        chk("vec_rd_wready", {bus.wready_1, bus.wready_0}, 32'd0);
        step(); #2;
        chk("vec_rvalid", p ? bus.rvalid_1 : bus.rvalid_0, 32'd1);
        chk("vec_rdone",  p ? bus.done_1 : bus.done_0, 32'd1);
        chk("vec_rdata",  bus.rdata, vt[i].exp_rdata);
      end
    end

    // 4-word read burst on port 0
    step();
    drive_port(1'b0, 1'b1, 1'b1, START_ADDR + 32'h10, SIZE_4, 32'h0);
    #2;
    for (int c = 0; c < 5; c++) begin
      step();
      if (c == 0) bus.req_0 = 1'b0;
      #2;
      if (c < 4) chk("br_maddr", bus.mem_address, START_ADDR + 32'h10 + 32'(4 * c));
      chk("br_men", bus.mem_enable, (c < 4) ? 32'd1 : 32'd0);
      chk("br_gnt0", bus.gnt_0, (c == 0) ? 32'd1 : 32'd0);
      chk("br_rvalid0", bus.rvalid_0, (c >= 1) ? 32'd1 : 32'd0);
      if (c >= 1) chk("br_rdata", bus.rdata, 32'h11 * c);
      chk("br_done0", bus.done_0, (c == 4) ? 32'd1 : 32'd0);
      chk("br_port1_quiet", {bus.gnt_1, bus.wready_1, bus.rvalid_1, bus.done_1}, 32'd0);
    end

    // 8-word write on port 1, memory busy for 3 cycles after beat 3
    step();
    drive_port(1'b1, 1'b1, 1'b0, START_ADDR + 32'h40, SIZE_8, 32'hB000_0000);
    #2;
    nw = 0;
    for (int c = 0; c < 11; c++) begin
      step();
      if (c == 0) bus.req_1 = 1'b0;
      bsy = (c >= 3 && c <= 5);
      eb  = (c < 3) ? c : (bsy ? 3 : c - 3);
      bus.mem_busy = bsy;
      bus.wdata_1  = 32'hB000_0000 + 32'(eb);
      #2;
      chk("bw_maddr",  bus.mem_address, START_ADDR + 32'h40 + 32'(4 * eb));
      chk("bw_mdin",   bus.mem_data_in, 32'hB000_0000 + 32'(eb));
      chk("bw_wready", bus.wready_1, bsy ? 32'd0 : 32'd1);
      chk("bw_done",   bus.done_1, (c == 10) ? 32'd1 : 32'd0);
      if (bus.wready_1) nw++;
    end
    step();
    bus.mem_busy = 1'b0;
    #2;
    chk("bw_pulses", nw, 32'd8);
    chk("bw_idle_men", bus.mem_enable, 32'd0);
    chk("bw_mem_last", mem[23], 32'hB000_0007);

    // Reset during beat 5 of a 16-word read
    step();
    drive_port(1'b0, 1'b1, 1'b1, START_ADDR + 32'h80, SIZE_16, 32'h0);
    #2;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) bus.req_0 = 1'b0;
      #2;
      chk("rm_no_done", bus.done_0, 32'd0);
    end
    step();
    chk("rm_beat5_addr", bus.mem_address, START_ADDR + 32'h90);
    reset_n = 1'b0;
    #1;
    chk_zero("rm_reset");
    @(negedge clock);
    reset_n = 1'b1;
    step();
    drive_port(1'b1, 1'b1, 1'b0, START_ADDR + 32'h8, SIZE_1, 32'hCAFE_F00D);
    #2;
    chk("rm_quiet", {bus.rvalid_0, bus.done_0, bus.gnt_1}, 32'd0);
    step();
    bus.req_1 = 1'b0;
    #2;
    chk("rm_gnt1",    bus.gnt_1, 32'd1);
    chk("rm_wready1", bus.wready_1, 32'd1);
    chk("rm_done1",   bus.done_1, 32'd1);
    chk("rm_maddr",   bus.mem_address, START_ADDR + 32'h8);
    chk("rm_mdin",    bus.mem_data_in, 32'hCAFE_F00D);
    step(); #2;
    chk("rm_after", {bus.rvalid_0, bus.done_0, bus.mem_enable}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
